// File: rtl/k12a_dma_arbiter.sv
// K12A memory-bus arbiter: shares address/data bus and ROM/RAM enables between
// the CPU control FSM and one byte-wide DMA/debug requester.
module k12a_dma_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_mem_req,
  input  logic        cpu_halted,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  input  logic [7:0]  data_bus_in,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic        cpu_hold,
  output logic        bus_sel_dma,
  output logic [15:0] dma_addr_bus,
  output logic [7:0]  dma_data_bus,
  output logic        dma_mem_enable,
  output logic        dma_mem_write,
  output logic        dma_async_write
);

  localparam int unsigned CNT_W = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WR_SETUP,
    WR_STROBE,
    ACK
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] starve_cnt;
  logic [15:0]      addr_q;
  logic [7:0]       wdata_q;
  logic [7:0]       rdata_q;
  logic             we_q;
  logic             async_wr_q;
  logic             grant;

  assign grant = (state == IDLE) && dma_req &&
                 (!cpu_mem_req || cpu_halted || (starve_cnt == CNT_MAX));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      async_wr_q <= 1'b0;
    end else begin
      if (grant) begin
        addr_q     <= dma_addr;
        wdata_q    <= dma_wdata;
        we_q       <= dma_we;
        starve_cnt <= '0;
      end else if ((state == IDLE) && dma_req && (starve_cnt != CNT_MAX)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
      if (state == READ) begin
        rdata_q <= data_bus_in;
      end
      // Strobe is a flop so WE sees a clean edge one full cycle after addr/data settle.
      async_wr_q <= (state_nx == WR_STROBE);
    end
  end

  always_comb begin
    state_nx       = state;
    dma_ack        = 1'b0;
    cpu_hold       = 1'b0;
    bus_sel_dma    = 1'b0;
    dma_addr_bus   = '0;
    dma_data_bus   = '0;
    dma_mem_enable = 1'b0;
    dma_mem_write  = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant) begin
          state_nx = dma_we ? WR_SETUP : READ;
        end
      end
      READ: begin
        cpu_hold       = 1'b1;
        bus_sel_dma    = 1'b1;
        dma_addr_bus   = addr_q;
        dma_mem_enable = 1'b1;
        state_nx       = ACK;
      end
      WR_SETUP, WR_STROBE: begin
        cpu_hold       = 1'b1;
        bus_sel_dma    = 1'b1;
        dma_addr_bus   = addr_q;
        dma_data_bus   = wdata_q;
        dma_mem_enable = 1'b1;
        dma_mem_write  = we_q;
        state_nx       = (state == WR_SETUP) ? WR_STROBE : ACK;
      end
      ACK: begin
        dma_ack  = 1'b1;
        cpu_hold = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign dma_rdata       = rdata_q;
  assign dma_async_write = async_wr_q;

endmodule

// File: tb/tb_k12a_dma_arbiter.sv
// Self-checking bench for k12a_dma_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a transfer-level reference model.
module tb_k12a_dma_arbiter;

  localparam int LIMIT = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_mem_req = 1'b0;
  logic        cpu_halted = 1'b0;
  logic        dma_req = 1'b0;
  logic        dma_we = 1'b0;
  logic [15:0] dma_addr = '0;
  logic [7:0]  dma_wdata = '0;
  logic [7:0]  data_bus_in;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic        cpu_hold;
  logic        bus_sel_dma;
  logic [15:0] dma_addr_bus;
  logic [7:0]  dma_data_bus;
  logic        dma_mem_enable;
  logic        dma_mem_write;
  logic        dma_async_write;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [7:0] ram [65536];
  logic [7:0] ref_mem [65536];

  k12a_dma_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .cpu_mem_req    (cpu_mem_req),
    .cpu_halted     (cpu_halted),
    .dma_req        (dma_req),
    .dma_we         (dma_we),
    .dma_addr       (dma_addr),
    .dma_wdata      (dma_wdata),
    .data_bus_in    (data_bus_in),
    .dma_ack        (dma_ack),
    .dma_rdata      (dma_rdata),
    .cpu_hold       (cpu_hold),
    .bus_sel_dma    (bus_sel_dma),
    .dma_addr_bus   (dma_addr_bus),
    .dma_data_bus   (dma_data_bus),
    .dma_mem_enable (dma_mem_enable),
    .dma_mem_write  (dma_mem_write),
    .dma_async_write(dma_async_write)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory: OE drives read data, otherwise the bus floats to junk.
  assign data_bus_in = (dma_mem_enable && !dma_mem_write) ? ram[dma_addr_bus] : (8'hC3 ^ 8'(cyc));
  always @(posedge clock)
    if (dma_async_write && dma_mem_enable && dma_mem_write) ram[dma_addr_bus] <= dma_data_bus;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: one transfer record with an offset from its grant cycle.
  bit          m_busy = 0;
  int          m_k = 0;
  bit          m_we = 0;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_wdata = '0;
  logic [7:0]  m_rdata = '0;
  int          m_refused = 0;

  always @(negedge clock) begin : compare
    logic [37:0] act_v;
    logic [37:0] exp_v;
    int len;
    act_v = {dma_ack, dma_rdata, cpu_hold, bus_sel_dma, dma_addr_bus, dma_data_bus,
             dma_mem_enable, dma_mem_write, dma_async_write};
    if (!reset_n) begin
      m_busy = 0; m_k = 0; m_refused = 0; m_rdata = '0;
      chk("reset_outputs", 64'(act_v), 64'(0));
    end else begin
      if (m_busy) begin
        len = m_we ? 3 : 2;
        if (m_k == len) begin
          if (m_we) ref_mem[m_addr] = m_wdata;
          else m_rdata = ref_mem[m_addr];
          exp_v = {1'b1, m_rdata, 1'b1, 1'b0, 16'h0000, 8'h00, 3'b000};
          m_busy = 0;
        end else begin
          exp_v = {1'b0, m_rdata, 1'b1, 1'b1, m_addr, (m_we ? m_wdata : 8'h00),
                   1'b1, m_we, (m_we && m_k == 2)};
          m_k++;
        end
      end else begin
        exp_v = {1'b0, m_rdata, 29'h0};
        if (dma_req && (!cpu_mem_req || cpu_halted || m_refused >= LIMIT)) begin
          m_busy = 1; m_k = 1; m_we = dma_we; m_addr = dma_addr; m_wdata = dma_wdata;
          m_refused = 0;
        end else if (dma_req && m_refused < LIMIT) begin
          m_refused++;
        end
      end
      chk("cycle_outputs", 64'(act_v), 64'(exp_v));
    end
  end

  task automatic next_drive();
    @(posedge clock);
    #1;
  endtask

  task automatic new_op();
    dma_req = 1'b1;
    dma_we = 1'($urandom);
    dma_wdata = 8'($urandom);
    if ($urandom_range(0, 3) == 0) dma_addr = 16'($urandom_range(0, 7));
    else dma_addr = 16'h8000 | 16'($urandom_range(0, 7));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end

  initial begin : stim
    int n;
    int acks;
    int gaps;
    logic a;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[16'h8010] = 8'hA5;
    ref_mem[16'h8010] = 8'hA5;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Idle-CPU read
    next_drive();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h8010;
    @(negedge clock);
    chk("rd_T_sel", bus_sel_dma, 0);
    chk("rd_T_hold", cpu_hold, 0);
    @(negedge clock);
    chk("rd_T1_sel", bus_sel_dma, 1);
    chk("rd_T1_hold", cpu_hold, 1);
    chk("rd_T1_addr", dma_addr_bus, 16'h8010);
    @(negedge clock);
    chk("rd_T2_ack", dma_ack, 1);
    chk("rd_T2_rdata", dma_rdata, 8'hA5);
    chk("rd_T2_hold", cpu_hold, 1);
    next_drive();
    dma_req = 1'b0;
    @(negedge clock);
    chk("rd_T3_hold", cpu_hold, 0);
    chk("rd_T3_ack", dma_ack, 0);
    chk("rd_T3_rdata_hold", dma_rdata, 8'hA5);

    // Write with setup/strobe/ack
    next_drive();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h8020; dma_wdata = 8'h3C;
    @(negedge clock);
    chk("wr_T_sel", bus_sel_dma, 0);
    @(negedge clock);
    chk("wr_T1_sel", bus_sel_dma, 1);
    chk("wr_T1_mwrite", dma_mem_write, 1);
    chk("wr_T1_strobe", dma_async_write, 0);
    chk("wr_T1_data", dma_data_bus, 8'h3C);
    @(negedge clock);
    chk("wr_T2_strobe", dma_async_write, 1);
    chk("wr_T2_addr", dma_addr_bus, 16'h8020);
    @(negedge clock);
    chk("wr_T3_ack", dma_ack, 1);
    chk("wr_T3_strobe", dma_async_write, 0);
    next_drive();
    dma_req = 1'b0;
    chk("wr_ram", ram[16'h8020], 8'h3C);

    // Starvation, twice to confirm the counter restarts from zero
    for (int rep = 0; rep < 2; rep++) begin
      next_drive();
      cpu_mem_req = 1'b1; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h8000 + 16'(rep);
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (!bus_sel_dma && n < 30);
      chk("starve_pending_cycles", n - 1, 9);
      @(negedge clock);
      chk("starve_ack", dma_ack, 1);
      next_drive();
      dma_req = 1'b0;
    end

    // Halted CPU grants at once
    next_drive();
    cpu_halted = 1'b1; cpu_mem_req = 1'b1; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h8010;
    @(negedge clock);
    chk("halt_T_sel", bus_sel_dma, 0);
    @(negedge clock);
    chk("halt_T1_sel", bus_sel_dma, 1);
    @(negedge clock);
    chk("halt_T2_ack", dma_ack, 1);
    next_drive();
    dma_req = 1'b0; cpu_halted = 1'b0; cpu_mem_req = 1'b0;

    // Back-to-back reads with request held high
    next_drive();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h8010;
    acks = 0; gaps = 0; n = 0;
    while (acks < 3 && n < 40) begin
      @(negedge clock);
      n++;
      if (dma_ack) acks++;
      else if (acks >= 1 && !cpu_hold) gaps++;
    end
    next_drive();
    dma_req = 1'b0;
    chk("b2b_acks", acks, 3);
    chk("b2b_unheld_gaps", gaps, 2);

    // Reset asserted during the write strobe
    next_drive();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h8030; dma_wdata = 8'h77;
    repeat (3) @(negedge clock);
    chk("rst_pre_strobe", dma_async_write, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_strobe", dma_async_write, 0);
    chk("rst_async_sel", bus_sel_dma, 0);
    chk("rst_async_hold", cpu_hold, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1; dma_req = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clock);
      if (dma_ack) acks++;
    end
    chk("rst_no_ack", acks, 0);

    // Randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      a = dma_ack;
      next_drive();
      cpu_mem_req = ($urandom_range(0, 99) < 80);
      cpu_halted = ($urandom_range(0, 99) < 5);
      if (dma_req) begin
        if (a) begin
          if ($urandom_range(0, 1) == 1) new_op();
          else dma_req = 1'b0;
        end else if ($urandom_range(0, 99) < 3) begin
          dma_req = 1'b0;
        end
      end else if ($urandom_range(0, 99) < 40) begin
        new_op();
      end
    end
    next_drive();
    dma_req = 1'b0;
    repeat (5) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
